// File: rtl/id_ex_stage_pkg.sv
// Shared RISC-V definitions: ALU ops, forward selects and the ID/EX bundle.
// Imported by the ID/EX stage, its forwarding unit and its interface.
package riscv_definitions;

    localparam int RV_XLEN  = 32;
    localparam int RV_REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ops_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        alu_ops_t              alu_op;
        logic [RV_XLEN-1:0]    pc;
        logic [RV_XLEN-1:0]    imm;
        logic [RV_REG_W-1:0]   rs1_addr;
        logic [RV_REG_W-1:0]   rs2_addr;
        logic [RV_XLEN-1:0]    rs1_data;
        logic [RV_XLEN-1:0]    rs2_data;
        logic                  use_pc;
        logic                  use_imm;
        logic [RV_REG_W-1:0]   rd_addr;
        logic                  reg_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and ALU-side handshake bundle of the ID/EX stage.
// slave: the stage; master: whoever drives decode and consumes the ALU side.
interface id_ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    import riscv_definitions::*;

    logic                  id_valid;
    logic                  id_ready;
    alu_ops_t              id_alu_op;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_imm;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic                  id_use_pc;
    logic                  id_use_imm;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;

    logic                  ex_valid;
    logic                  ex_ready;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    alu_ops_t              alu_op;
    logic [XLEN-1:0]       ex_rs2_data;
    logic [XLEN-1:0]       ex_pc;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    fwd_sel_t              fwd_a_sel;
    fwd_sel_t              fwd_b_sel;

    modport slave (
        input  id_valid, id_alu_op, id_pc, id_imm,
        input  id_rs1_addr, id_rs2_addr,
        input  id_rs1_data, id_rs2_data,
        input  id_use_pc, id_use_imm,
        input  id_rd_addr, id_reg_write,
        input  ex_ready,
        output id_ready, ex_valid,
        output operand_a, operand_b, alu_op,
        output ex_rs2_data, ex_pc,
        output ex_rd_addr, ex_reg_write,
        output fwd_a_sel, fwd_b_sel
    );

    modport master (
        output id_valid, id_alu_op, id_pc, id_imm,
        output id_rs1_addr, id_rs2_addr,
        output id_rs1_data, id_rs2_data,
        output id_use_pc, id_use_imm,
        output id_rd_addr, id_reg_write,
        output ex_ready,
        input  id_ready, ex_valid,
        input  operand_a, operand_b, alu_op,
        input  ex_rs2_data, ex_pc,
        input  ex_rd_addr, ex_reg_write,
        input  fwd_a_sel, fwd_b_sel
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding source select for one register operand.
// In: held rs index/data, EX/MEM and MEM/WB writers. Out: select, value.
module fwd_unit
    import riscv_definitions::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]       mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_result,
    output fwd_sel_t              sel,
    output logic [XLEN-1:0]       value
);

    logic rs_nz;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        rs_nz   = (rs_addr != '0);
        mem_hit = mem_reg_write && (mem_rd_addr == rs_addr) && rs_nz;
        wb_hit  = wb_reg_write && (wb_rd_addr == rs_addr) && rs_nz;

        // The younger producer (EX/MEM) wins over MEM/WB.
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end

        // x0 reads as zero whatever the register file returned.
        value = rs_nz ? rs_data : '0;
        unique case (sel)
            FWD_MEM: value = mem_result;
            FWD_WB:  value = wb_result;
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW forwarding and flush.
// Ports: clk, reset (async low), flush, bus (slave), EX/MEM + MEM/WB writers.
module id_ex_stage
    import riscv_definitions::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    id_ex_stage_if.slave          bus,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]       mem_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_result
);

    id_ex_t          held_q, held_d;
    logic            ex_valid_q, ex_valid_d;
    logic            accept;
    logic            wb_nz;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    fwd_sel_t        sel_rs1, sel_rs2;

    assign bus.id_ready = !ex_valid_q || bus.ex_ready || flush;
    // A flushed input is taken off the bus but never lands.
    assign accept = bus.id_valid && bus.id_ready && !flush;
    assign wb_nz  = wb_reg_write && (wb_rd_addr != '0);

    always_comb begin
        held_d     = held_q;
        ex_valid_d = ex_valid_q;

        // Keep held sources current so a writeback during a stall is
        // not lost once it leaves the MEM/WB forward window.
        if (wb_nz && (wb_rd_addr == held_q.rs1_addr)) begin
            held_d.rs1_data = wb_result;
        end
        if (wb_nz && (wb_rd_addr == held_q.rs2_addr)) begin
            held_d.rs2_data = wb_result;
        end

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d       = 1'b1;
            held_d.alu_op    = bus.id_alu_op;
            held_d.pc        = bus.id_pc;
            held_d.imm       = bus.id_imm;
            held_d.rs1_addr  = bus.id_rs1_addr;
            held_d.rs2_addr  = bus.id_rs2_addr;
            held_d.rs1_data  = bus.id_rs1_data;
            held_d.rs2_data  = bus.id_rs2_data;
            held_d.use_pc    = bus.id_use_pc;
            held_d.use_imm   = bus.id_use_imm;
            held_d.rd_addr   = bus.id_rd_addr;
            held_d.reg_write = bus.id_reg_write;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // All-zero bundle decodes as ALU_ADD with x0 sources.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            held_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            held_q     <= held_d;
        end
    end

    fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr       (held_q.rs1_addr),
        .rs_data       (held_q.rs1_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .sel           (sel_rs1),
        .value         (fwd_rs1)
    );

    fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr       (held_q.rs2_addr),
        .rs_data       (held_q.rs2_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .sel           (sel_rs2),
        .value         (fwd_rs2)
    );

    assign bus.ex_valid     = ex_valid_q;
    assign bus.alu_op       = held_q.alu_op;
    assign bus.operand_a    = held_q.use_pc ? held_q.pc : fwd_rs1;
    assign bus.operand_b    = held_q.use_imm ? held_q.imm : fwd_rs2;
    assign bus.ex_rs2_data  = fwd_rs2;
    assign bus.ex_pc        = held_q.pc;
    assign bus.ex_rd_addr   = held_q.rd_addr;
    assign bus.ex_reg_write = held_q.reg_write && ex_valid_q;
    assign bus.fwd_a_sel    = sel_rs1;
    assign bus.fwd_b_sel    = sel_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: architectural model plus literal checks.
// The model tracks the newest known value of every register.
module tb_id_ex_stage;
    import riscv_definitions::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        mem_rw;
    logic [4:0]  mem_rd;
    logic [31:0] mem_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;

    int total;
    int bad;

    id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .flush         (flush),
        .bus           (bus),
        .mem_reg_write (mem_rw),
        .mem_rd_addr   (mem_rd),
        .mem_result    (mem_res),
        .wb_reg_write  (wb_rw),
        .wb_rd_addr    (wb_rd),
        .wb_result     (wb_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    logic        m_valid;
    logic [3:0]  m_op;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        m_upc, m_uimm, m_rw;
    logic [31:0] known [32];

    function automatic logic [31:0] src_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (mem_rw && mem_rd == a) return mem_res;
        if (wb_rw && wb_rd == a) return wb_res;
        return known[a];
    endfunction

    function automatic logic [1:0] src_sel(input logic [4:0] a);
        if (a == 5'd0) return 2'd0;
        if (mem_rw && mem_rd == a) return 2'd1;
        if (wb_rw && wb_rd == a) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_op    <= 4'd0;
            m_pc    <= '0;
            m_imm   <= '0;
            m_rs1   <= '0;
            m_rs2   <= '0;
            m_rd    <= '0;
            m_upc   <= 1'b0;
            m_uimm  <= 1'b0;
            m_rw    <= 1'b0;
            for (int i = 0; i < 32; i++) known[i] <= '0;
        end else begin
            if (wb_rw) known[wb_rd] <= wb_res;
            if (flush) begin
                m_valid <= 1'b0;
            end else if (bus.id_valid && (!m_valid || bus.ex_ready)) begin
                m_valid <= 1'b1;
                m_op    <= bus.id_alu_op;
                m_pc    <= bus.id_pc;
                m_imm   <= bus.id_imm;
                m_rs1   <= bus.id_rs1_addr;
                m_rs2   <= bus.id_rs2_addr;
                m_rd    <= bus.id_rd_addr;
                m_upc   <= bus.id_use_pc;
                m_uimm  <= bus.id_use_imm;
                m_rw    <= bus.id_reg_write;
                // later NBA wins over the writeback on the same index
                known[bus.id_rs1_addr] <= bus.id_rs1_data;
                known[bus.id_rs2_addr] <= bus.id_rs2_data;
            end else if (bus.ex_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
            chk("m_id_ready", {31'd0, bus.id_ready},
                {31'd0, !m_valid || bus.ex_ready || flush});
            if (m_valid) begin
                chk("m_alu_op", {28'd0, bus.alu_op}, {28'd0, m_op});
                chk("m_op_a", bus.operand_a,
                    m_upc ? m_pc : src_val(m_rs1));
                chk("m_op_b", bus.operand_b,
                    m_uimm ? m_imm : src_val(m_rs2));
                chk("m_rs2_data", bus.ex_rs2_data, src_val(m_rs2));
                chk("m_ex_pc", bus.ex_pc, m_pc);
                chk("m_rd", {27'd0, bus.ex_rd_addr}, {27'd0, m_rd});
                chk("m_reg_write", {31'd0, bus.ex_reg_write},
                    {31'd0, m_rw});
                chk("m_sel_a", {30'd0, bus.fwd_a_sel},
                    {30'd0, src_sel(m_rs1)});
                chk("m_sel_b", {30'd0, bus.fwd_b_sel},
                    {30'd0, src_sel(m_rs2)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_ops_t op,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic upc, input logic uimm,
                         input logic [4:0] rd, input logic rw);
        bus.id_valid     = 1'b1;
        bus.id_alu_op    = op;
        bus.id_rs1_addr  = r1;
        bus.id_rs1_data  = d1;
        bus.id_rs2_addr  = r2;
        bus.id_rs2_data  = d2;
        bus.id_pc        = pc;
        bus.id_imm       = imm;
        bus.id_use_pc    = upc;
        bus.id_use_imm   = uimm;
        bus.id_rd_addr   = rd;
        bus.id_reg_write = rw;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        mem_rw = 1'b0; mem_rd = '0; mem_res = '0;
        wb_rw  = 1'b0; wb_rd  = '0; wb_res  = '0;
        bus.ex_ready = 1'b1;
        drive(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 5'd0, 1'b0);
        bus.id_valid = 1'b0;

        // reset values
        #2;
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_op", {28'd0, bus.alu_op}, 32'd0);
        chk("rst_a", bus.operand_a, 32'd0);
        chk("rst_b", bus.operand_b, 32'd0);
        chk("rst_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // basic pass
        drive(ALU_ADD, 5'd1, 32'd10, 5'd2, 32'd15, 32'h40, 32'd0,
              1'b0, 1'b0, 5'd3, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("basic_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("basic_a", bus.operand_a, 32'd10);
        chk("basic_b", bus.operand_b, 32'd15);
        chk("basic_op", {28'd0, bus.alu_op}, 32'd0);
        chk("basic_rw", {31'd0, bus.ex_reg_write}, 32'd1);
        tick();

        // reset mid-stream
        bus.ex_ready = 1'b0;
        drive(ALU_SUB, 5'd1, 32'd7, 5'd2, 32'd8, 32'h44, 32'd0,
              1'b0, 1'b0, 5'd4, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", {31'd0, bus.ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("mid_op", {28'd0, bus.alu_op}, 32'd0);
        chk("mid_a", bus.operand_a, 32'd0);
        chk("mid_b", bus.operand_b, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.ex_ready = 1'b1;

        // forward priority
        drive(ALU_ADD, 5'd5, 32'd1, 5'd6, 32'd2, 32'h48, 32'd0,
              1'b0, 1'b0, 5'd7, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        mem_rw = 1'b1; mem_rd = 5'd5; mem_res = 32'h20;
        wb_rw  = 1'b1; wb_rd  = 5'd5; wb_res  = 32'h30;
        #1;
        chk("fwd_mem", bus.operand_a, 32'h20);
        chk("fwd_mem_sel", {30'd0, bus.fwd_a_sel}, 32'd1);
        mem_rw = 1'b0;
        #1;
        chk("fwd_wb", bus.operand_a, 32'h30);
        chk("fwd_wb_sel", {30'd0, bus.fwd_a_sel}, 32'd2);
        tick();
        wb_rw = 1'b0;
        #1;
        chk("fwd_refresh", bus.operand_a, 32'h30);
        bus.ex_ready = 1'b1;
        drive(ALU_ADD, 5'd0, 32'h99, 5'd6, 32'd2, 32'h4c, 32'd0,
              1'b0, 1'b0, 5'd7, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        mem_rw = 1'b1; mem_rd = 5'd0; mem_res = 32'h44;
        wb_rw  = 1'b1; wb_rd  = 5'd0; wb_res  = 32'h66;
        #1;
        chk("fwd_x0", bus.operand_a, 32'd0);
        tick();
        mem_rw = 1'b0;
        wb_rw  = 1'b0;
        #1;
        chk("fwd_x0_held", bus.operand_a, 32'd0);
        bus.ex_ready = 1'b1;
        tick();

        // stall refresh
        drive(ALU_ADD, 5'd1, 32'd3, 5'd2, 32'd4, 32'h50, 32'd0,
              1'b0, 1'b0, 5'd8, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        @(negedge clk);
        chk("stall1_b", bus.operand_b, 32'd4);
        chk("stall1_rdy", {31'd0, bus.id_ready}, 32'd0);
        tick();
        wb_rw = 1'b1; wb_rd = 5'd2; wb_res = 32'h55;
        @(negedge clk);
        chk("stall2_b", bus.operand_b, 32'h55);
        chk("stall2_rdy", {31'd0, bus.id_ready}, 32'd0);
        tick();
        wb_rw = 1'b0;
        @(negedge clk);
        chk("stall3_b", bus.operand_b, 32'h55);
        chk("stall3_rdy", {31'd0, bus.id_ready}, 32'd0);
        tick();
        bus.ex_ready = 1'b1;
        @(negedge clk);
        chk("release_b", bus.operand_b, 32'h55);
        chk("release_valid", {31'd0, bus.ex_valid}, 32'd1);
        tick();

        // immediate / PC select
        drive(ALU_ADD, 5'd4, 32'd1, 5'd3, 32'd9, 32'h100,
              32'hFFFF_FFFC, 1'b1, 1'b1, 5'd9, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        mem_rw = 1'b1; mem_rd = 5'd3; mem_res = 32'd7;
        @(negedge clk);
        chk("sel_a_pc", bus.operand_a, 32'h100);
        chk("sel_b_imm", bus.operand_b, 32'hFFFF_FFFC);
        chk("sel_rs2", bus.ex_rs2_data, 32'd7);
        tick();
        mem_rw = 1'b0;

        // flush vs accept, with a stalled instruction still held
        flush = 1'b1;
        drive(ALU_OR, 5'd1, 32'd1, 5'd2, 32'd2, 32'h104, 32'd0,
              1'b0, 1'b0, 5'd10, 1'b1);
        #1;
        chk("flush_rdy", {31'd0, bus.id_ready}, 32'd1);
        tick();
        flush = 1'b0;
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_rw", {31'd0, bus.ex_reg_write}, 32'd0);
        tick();

        // back-to-back stream
        bus.ex_ready = 1'b1;
        drive(ALU_SUB, 5'd1, 32'd20, 5'd2, 32'd5, 32'h200, 32'd0,
              1'b0, 1'b0, 5'd11, 1'b1);
        tick();
        drive(ALU_SLT, 5'd1, 32'd10, 5'd2, 32'd20, 32'h204, 32'd0,
              1'b0, 1'b0, 5'd12, 1'b1);
        @(negedge clk);
        chk("b2b1_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("b2b1_op", {28'd0, bus.alu_op}, 32'd1);
        chk("b2b1_a", bus.operand_a, 32'd20);
        chk("b2b1_b", bus.operand_b, 32'd5);
        tick();
        bus.id_valid = 1'b0;
        @(negedge clk);
        chk("b2b2_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("b2b2_op", {28'd0, bus.alu_op}, 32'd3);
        chk("b2b2_a", bus.operand_a, 32'd10);
        chk("b2b2_b", bus.operand_b, 32'd20);
        tick();
        @(negedge clk);
        chk("drain_valid", {31'd0, bus.ex_valid}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
